// File: rtl/des_key_schedule_if.sv
// Subkey stream bundle between the DES key schedule and the round datapath.
// PARITY_ERR exists only when DES_KEY_PARITY_CHECK_EN is defined.
interface des_key_schedule_if;
  logic        START;
  logic        DECRYPT;
  logic [64:1] KEY;
  logic        KEY_READY;
  logic [48:1] ROUND_KEY;
  logic        KEY_VALID;
  logic [4:0]  ROUND_NUM;
  logic        KEY_LAST;
  logic        BUSY;
  logic        DONE;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        PARITY_ERR;

  modport master (
    output START, DECRYPT, KEY, KEY_READY,
    input  ROUND_KEY, KEY_VALID, ROUND_NUM, KEY_LAST, BUSY, DONE, PARITY_ERR
  );

  modport slave (
    input  START, DECRYPT, KEY, KEY_READY,
    output ROUND_KEY, KEY_VALID, ROUND_NUM, KEY_LAST, BUSY, DONE, PARITY_ERR
  );
`else
  modport master (
    output START, DECRYPT, KEY, KEY_READY,
    input  ROUND_KEY, KEY_VALID, ROUND_NUM, KEY_LAST, BUSY, DONE
  );

  modport slave (
    input  START, DECRYPT, KEY, KEY_READY,
    output ROUND_KEY, KEY_VALID, ROUND_NUM, KEY_LAST, BUSY, DONE
  );
`endif
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1, per-round C/D rotation, PC-2, one subkey per handshake.
// Optional DES_KEY_PARITY_CHECK_EN rejects keys whose bytes lack odd parity.
module des_key_schedule (
  input  logic            CLK,
  input  logic            RST,
  des_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;
  typedef enum logic [1:0] {CD_HOLD, CD_LOAD, CD_ADV} cd_op_e;
  typedef enum logic [1:0] {RK_HOLD, RK_NEW, RK_CLEAR} rk_op_e;

  // Leftmost entry is round 1.
  localparam logic [31:0] SHIFT_TABLE = {
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [56*8-1:0] PC1_TAB = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
    8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd60, 8'd52, 8'd44, 8'd36, 8'd63, 8'd55, 8'd47, 8'd39,
    8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38,
    8'd30, 8'd22, 8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37,
    8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam logic [48*8-1:0] PC2_TAB = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
    8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
    8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
    8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
    8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  function automatic logic [1:0] shift_of(input logic [4:0] r);
    logic [4:0] idx;
    idx = 5'd16 - r;
    return SHIFT_TABLE[{idx[3:0], 1'b0} +: 2];
  endfunction

  function automatic logic [28:1] rol28(input logic [28:1] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[26:1], x[28:27]} : {x[27:1], x[28]};
  endfunction

  function automatic logic [28:1] ror28(input logic [28:1] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[2:1], x[28:3]} : {x[1], x[28:2]};
  endfunction

  state_e      state_q, state_d;
  cd_op_e      cd_op;
  rk_op_e      rk_op;
  logic [56:1] cd_q, cd_d;
  logic [48:1] rk_q, rk_d;
  logic        valid_q, valid_d;
  logic [4:0]  num_q, num_d;
  logic        dec_q, dec_d;
  logic [56:1] pc1_key;
  logic [48:1] pc2_d;
  logic        key_last;
  logic        key_ok;

  // Tables use FIPS numbering (bit 1 = MSB); vectors here are [n:1] with bit i at index n+1-i.
  for (genvar gi = 1; gi <= 56; gi++) begin : g_pc1
    localparam int SRC = 65 - int'(PC1_TAB[(56-gi)*8 +: 8]);
    assign pc1_key[57-gi] = bus.KEY[SRC];
  end

  for (genvar gi = 1; gi <= 48; gi++) begin : g_pc2
    localparam int SRC = 57 - int'(PC2_TAB[(48-gi)*8 +: 8]);
    assign pc2_d[49-gi] = cd_d[SRC];
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] byte_odd;
  logic       parity_err_q, parity_err_d;

  for (genvar gi = 0; gi < 8; gi++) begin : g_parity
    assign byte_odd[gi] = ^bus.KEY[8*gi+8 : 8*gi+1];
  end
  assign key_ok         = &byte_odd;
  assign bus.PARITY_ERR = parity_err_q;
`else
  assign key_ok = 1'b1;
`endif

  assign key_last = valid_q & ((!dec_q && num_q == 5'd16) || (dec_q && num_q == 5'd1));

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    num_d   = num_q;
    dec_d   = dec_q;
    cd_op   = CD_HOLD;
    rk_op   = RK_HOLD;
`ifdef DES_KEY_PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          if (key_ok) begin
            state_d = S_RUN;
            dec_d   = bus.DECRYPT;
            valid_d = 1'b1;
            num_d   = bus.DECRYPT ? 5'd16 : 5'd1;
            cd_op   = CD_LOAD;
            rk_op   = RK_NEW;
          end
`ifdef DES_KEY_PARITY_CHECK_EN
          else begin
            parity_err_d = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        if (valid_q && bus.KEY_READY) begin
          if (key_last) begin
            state_d = S_FIN;
            valid_d = 1'b0;
            num_d   = 5'd0;
            rk_op   = RK_CLEAR;
          end else begin
            num_d = dec_q ? num_q - 5'd1 : num_q + 5'd1;
            cd_op = CD_ADV;
            rk_op = RK_NEW;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decrypt starts from C16/D16, which equal C0/D0 because the shifts sum to 28.
  always_comb begin
    cd_d = cd_q;
    case (cd_op)
      CD_LOAD: begin
        if (bus.DECRYPT) cd_d = pc1_key;
        else cd_d = {rol28(pc1_key[56:29], shift_of(5'd1)), rol28(pc1_key[28:1], shift_of(5'd1))};
      end
      CD_ADV: begin
        if (dec_q) cd_d = {ror28(cd_q[56:29], shift_of(num_q)), ror28(cd_q[28:1], shift_of(num_q))};
        else cd_d = {rol28(cd_q[56:29], shift_of(num_q + 5'd1)),
                     rol28(cd_q[28:1], shift_of(num_q + 5'd1))};
      end
      default: ;
    endcase
  end

  always_comb begin
    rk_d = rk_q;
    case (rk_op)
      RK_NEW:   rk_d = pc2_d;
      RK_CLEAR: rk_d = '0;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cd_q    <= '0;
      rk_q    <= '0;
      valid_q <= 1'b0;
      num_q   <= 5'd0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      rk_q    <= rk_d;
      valid_q <= valid_d;
      num_q   <= num_d;
      dec_q   <= dec_d;
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RST) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end
`endif

  assign bus.ROUND_KEY = rk_q;
  assign bus.KEY_VALID = valid_q;
  assign bus.ROUND_NUM = num_q;
  assign bus.KEY_LAST  = key_last;
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.DONE      = (state_q == S_FIN);

endmodule
